conv_seq_engine: RTL

Parametrised single-MAC sequential 2-D convolution engine: the successor to the fixed 4×4-by-3×3 single-PE array. Takes an IN_N×IN_N image and a K×K kernel and computes every valid-window output, (IN_N−K+1)² in total, on one time-shared multiply-accumulate unit. Supports true convolution (kernel flipped) or correlation. Results stream out one at a time over a valid/ready handshake to the downstream buffer in the computation path.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/mac_unit.sv | 29 ++
 rtl/conv_seq_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state type, counter-width helper and output saturation
// for the sequential convolution engine. No ports.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

    // Counter width for a range of n values; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // min(v >> sh, 2^ow - 1); callers truncate the result to ow bits
    function automatic logic [63:0] sat(input logic [63:0] v, input int sh, input int ow);
        logic [63:0] s;
        logic [63:0] lim;
        s = v >> sh;
        lim = (64'd1 << ow) - 64'd1;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: unsigned DW x DW multiply-accumulate with a registered accumulator.
// Ports: clk, rst (sync, active-low), load (restart sum with this product),
// en (register the new sum), a/b (operands), sum (accumulator after this tap).
module mac_unit import conv_pkg::*; #(
    parameter int DW    = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] sum
);
    logic [ACC_W-1:0]  acc;
    logic [2*DW-1:0]   prod;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    // sum is exposed combinationally so the final tap can be saturated in the same cycle
    assign sum  = (load ? '0 : acc) + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (!rst)
            acc <= '0;
        else if (en)
            acc <= sum;
    end
endmodule

// File: rtl/conv_seq_engine.sv
// conv_seq_engine: single-MAC sequential 2-D convolution/correlation engine.
// Ports: clk, rst (sync, active-low), start/mode (run request, 0=convolution
// 1=correlation), img/kern (packed row-major operands), busy, done (one-cycle
// completion pulse), out_valid/out_ready/out_data/out_row/out_col (result stream).
module conv_seq_engine import conv_pkg::*; #(
    parameter int DW    = 8,
    parameter int IN_N  = 4,
    parameter int K     = 3,
    parameter int ACC_W = 20,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             mode,
    input  logic [IN_N*IN_N*DW-1:0]          img,
    input  logic [K*K*DW-1:0]                kern,
    output logic                             busy,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OW-1:0]                    out_data,
    output logic [cnt_w(IN_N-K+1)-1:0]       out_row,
    output logic [cnt_w(IN_N-K+1)-1:0]       out_col,
    output logic                             done
);
    localparam int ON = IN_N - K + 1;
    localparam int PW = cnt_w(ON);
    localparam int KW = cnt_w(K);
    localparam logic [PW-1:0] LAST = PW'(ON - 1);
    localparam logic [KW-1:0] KL   = KW'(K - 1);

    state_t                    state;
    logic [IN_N*IN_N*DW-1:0]   img_r;
    logic [K*K*DW-1:0]         kern_r;
    logic                      mode_r;
    logic [PW-1:0]             row, col;
    logic [KW-1:0]             ti, tj;
    logic [DW-1:0]             pix, wt;
    logic [ACC_W-1:0]          sum;
    int                        pi, wi;

    // Tap address muxing; convolution reads the kernel point-reflected
    always_comb begin
        pi  = ((int'(row) + int'(ti)) * IN_N + int'(col) + int'(tj)) * DW;
        wi  = (mode_r ? int'(ti) * K + int'(tj)
                      : (K - 1 - int'(ti)) * K + (K - 1 - int'(tj))) * DW;
        pix = img_r[pi +: DW];
        wt  = kern_r[wi +: DW];
    end

    mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .load (ti == '0 && tj == '0),
        .en   (state == MAC),
        .a    (pix),
        .b    (wt),
        .sum  (sum)
    );

    assign out_row = row;
    assign out_col = col;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            row       <= '0;
            col       <= '0;
            ti        <= '0;
            tj        <= '0;
            img_r     <= '0;
            kern_r    <= '0;
            mode_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    img_r  <= img;
                    kern_r <= kern;
                    mode_r <= mode;
                    row    <= '0;
                    col    <= '0;
                    ti     <= '0;
                    tj     <= '0;
                    busy   <= 1'b1;
                    state  <= MAC;
                end
                MAC: begin
                    tj <= (tj == KL) ? '0 : tj + 1'b1;
                    if (tj == KL)
                        ti <= (ti == KL) ? '0 : ti + 1'b1;
                    if (tj == KL && ti == KL) begin
                        out_valid <= 1'b1;
                        out_data  <= OW'(sat(64'(sum), SHIFT, OW));
                        state     <= OUT;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    col       <= (col == LAST) ? '0 : col + 1'b1;
                    if (col == LAST)
                        row <= (row == LAST) ? '0 : row + 1'b1;
                    done      <= (col == LAST && row == LAST);
                    state     <= (col == LAST && row == LAST) ? DONE : MAC;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
